// File: rtl/ex_issue_stage.sv
// ---------------------------------------------------------------------------
// ex_issue_stage
//
// ID/EX pipeline register with the ALU control decoder. Each cycle it takes
// one decoded instruction from ID and derives the 3-bit ALU code. It builds
// both ALU operands (rs value; rt value or the extended immediate) and
// registers everything as the EX-stage bundle.
//
// Optional feature macro: EX_ISSUE_FWD_EN
//   defined   - operands are forwarded from MEM/WB at capture time
//               (MEM beats WB, register 0 never forwarded).
//   undefined - forwarding ports are ignored; operands come from the
//               register file only.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall, flush          hold EX bundle / insert bubble (flush wins)
//   id_*                  decoded ID-stage bundle
//   mem_*, wb_*           forwarding sources (EX_ISSUE_FWD_EN only)
//   ex_valid, ex_ctrl     bundle valid, ALU operation code
//   ex_data1, ex_data2    ALU operands
//   ex_rt_data            store data (operand 2 before immediate select)
//   ex_wr_reg             destination register index
//   ex_reg_write,
//   ex_branch             control passthrough
//   ex_illegal            unsupported funct in the current bundle
//   illegal_seen          sticky illegal flag, cleared only by reset
// ---------------------------------------------------------------------------
module ex_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [1:0]  id_alu_op,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic        id_reg_write,
  input  logic        id_branch,
  input  logic        mem_reg_write,
  input  logic        wb_reg_write,
  input  logic [4:0]  mem_wr_reg,
  input  logic [4:0]  wb_wr_reg,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  output logic        ex_valid,
  output logic [2:0]  ex_ctrl,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [31:0] ex_rt_data,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_illegal,
  output logic        illegal_seen
);

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [2:0]  ctrl;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] rt_data;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic        branch;
    logic        illegal;
  } ex_bundle_t;

  localparam ex_bundle_t EX_BUBBLE = '{
    valid:     1'b0,
    ctrl:      ALU_PASS,
    data1:     32'd0,
    data2:     32'd0,
    rt_data:   32'd0,
    wr_reg:    5'd0,
    reg_write: 1'b0,
    branch:    1'b0,
    illegal:   1'b0
  };

  ex_bundle_t ex_q, ex_d, id_bundle;
  logic       illegal_seen_q, illegal_seen_d;

  logic [2:0]  ctrl_dec;
  logic        illegal_dec;
  logic [31:0] imm_ext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  // ALU control decode
  always_comb begin
    ctrl_dec    = ALU_PASS;
    illegal_dec = 1'b0;
    unique case (id_alu_op)
      2'b00: ctrl_dec = ALU_ADD;
      2'b01: ctrl_dec = ALU_SUB;
      2'b11: ctrl_dec = ALU_OR;
      default: begin
        case (id_funct)
          6'b100000: ctrl_dec = ALU_ADD;
          6'b100010: ctrl_dec = ALU_SUB;
          6'b100100: ctrl_dec = ALU_AND;
          6'b100101: ctrl_dec = ALU_OR;
          6'b100110: ctrl_dec = ALU_XOR;
          default: begin
            ctrl_dec    = ALU_PASS;
            illegal_dec = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Immediate-OR uses a zero-extended immediate; everything else sign-extends
  assign imm_ext = (id_alu_op == 2'b11) ? {16'd0, id_imm}
                                        : {{16{id_imm[15]}}, id_imm};

`ifdef EX_ISSUE_FWD_EN
  // Forwarding resolved at capture time; MEM is younger so it wins over WB
  always_comb begin
    rs_val = id_rs_data;
    if (mem_reg_write && (mem_wr_reg == id_rs) && (id_rs != 5'd0))
      rs_val = mem_result;
    else if (wb_reg_write && (wb_wr_reg == id_rs) && (id_rs != 5'd0))
      rs_val = wb_result;
  end

  always_comb begin
    rt_val = id_rt_data;
    if (mem_reg_write && (mem_wr_reg == id_rt) && (id_rt != 5'd0))
      rt_val = mem_result;
    else if (wb_reg_write && (wb_wr_reg == id_rt) && (id_rt != 5'd0))
      rt_val = wb_result;
  end
`else
  assign rs_val = id_rs_data;
  assign rt_val = id_rt_data;

  // Forwarding inputs have no function in this build
  logic unused_fwd;
  assign unused_fwd = ^{mem_reg_write, wb_reg_write, mem_wr_reg, wb_wr_reg,
                        mem_result, wb_result, id_rs};
`endif

  // Decoded ID bundle; an illegal funct suppresses the register write
  always_comb begin
    id_bundle           = EX_BUBBLE;
    id_bundle.valid     = 1'b1;
    id_bundle.ctrl      = ctrl_dec;
    id_bundle.data1     = rs_val;
    id_bundle.data2     = id_alu_src ? imm_ext : rt_val;
    id_bundle.rt_data   = rt_val;
    id_bundle.wr_reg    = id_reg_dst ? id_rd : id_rt;
    id_bundle.reg_write = id_reg_write & ~illegal_dec;
    id_bundle.branch    = id_branch;
    id_bundle.illegal   = illegal_dec;
  end

  // Next-state: flush beats stall; stall holds everything incl. the sticky flag
  always_comb begin
    ex_d           = ex_q;
    illegal_seen_d = illegal_seen_q;
    if (flush) begin
      ex_d = EX_BUBBLE;
    end else if (!stall) begin
      if (id_valid) begin
        ex_d           = id_bundle;
        illegal_seen_d = illegal_seen_q | illegal_dec;
      end else begin
        ex_d = EX_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q           <= EX_BUBBLE;
      illegal_seen_q <= 1'b0;
    end else begin
      ex_q           <= ex_d;
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_data1     = ex_q.data1;
  assign ex_data2     = ex_q.data2;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_wr_reg    = ex_q.wr_reg;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_branch    = ex_q.branch;
  assign ex_illegal   = ex_q.illegal;
  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_ex_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_issue_stage
//
// Directed self-checking bench for ex_issue_stage. Expected values are
// hand-computed constants. Forwarding expectations follow EX_ISSUE_FWD_EN.
// ---------------------------------------------------------------------------
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_branch;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_wr_reg, wb_wr_reg;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [2:0]  ex_ctrl;
  logic [31:0] ex_data1, ex_data2, ex_rt_data;
  logic [4:0]  ex_wr_reg;
  logic        ex_reg_write, ex_branch, ex_illegal, illegal_seen;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  ex_issue_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_branch(id_branch),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_wr_reg(mem_wr_reg), .wb_wr_reg(wb_wr_reg),
    .mem_result(mem_result), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_data1(ex_data1),
    .ex_data2(ex_data2), .ex_rt_data(ex_rt_data), .ex_wr_reg(ex_wr_reg),
    .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal), .illegal_seen(illegal_seen)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] rs_d, input logic [31:0] rt_d,
                           input logic [15:0] imm, input logic src,
                           input logic dst, input logic [4:0] rd);
    id_valid     = 1'b1;
    id_alu_op    = op;
    id_funct     = fn;
    id_rs_data   = rs_d;
    id_rt_data   = rt_d;
    id_imm       = imm;
    id_alu_src   = src;
    id_reg_dst   = dst;
    id_rd        = rd;
    id_rt        = 5'd3;
    id_rs        = 5'd2;
    id_reg_write = 1'b1;
    id_branch    = 1'b0;
  endtask

  task automatic check_bubble(input string tag);
    check_val({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    check_val({tag, "_ctrl"}, {29'd0, ex_ctrl}, 32'd3);
    check_val({tag, "_data1"}, ex_data1, 32'd0);
    check_val({tag, "_data2"}, ex_data2, 32'd0);
    check_val({tag, "_wr_reg"}, {27'd0, ex_wr_reg}, 32'd0);
    check_val({tag, "_reg_write"}, {31'd0, ex_reg_write}, 32'd0);
  endtask

  // R-type funct table: funct -> expected ctrl
  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};
  logic [2:0] ct_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_alu_op = 2'b00; id_funct = 6'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_rd = 5'd0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm = 16'd0;
    id_alu_src = 1'b0; id_reg_dst = 1'b0; id_reg_write = 1'b0;
    id_branch = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    mem_wr_reg = 5'd0; wb_wr_reg = 5'd0; mem_result = 32'd0; wb_result = 32'd0;

    // Reset for two cycles, with a valid instruction pending at the inputs
    set_instr(2'b10, 6'b100000, 32'h55, 32'h66, 16'h0, 1'b0, 1'b1, 5'd4);
    tick(); tick();
    check_bubble("reset");
    check_val("reset_seen", {31'd0, illegal_seen}, 32'd0);
    reset = 1'b0;

    // R-type sub
    set_instr(2'b10, 6'b100010, 32'd7, 32'd7, 16'h0, 1'b0, 1'b1, 5'd9);
    tick();
    check_val("sub_valid", {31'd0, ex_valid}, 32'd1);
    check_val("sub_ctrl", {29'd0, ex_ctrl}, 32'd6);
    check_val("sub_data1", ex_data1, 32'd7);
    check_val("sub_data2", ex_data2, 32'd7);
    check_val("sub_wr_reg", {27'd0, ex_wr_reg}, 32'd9);

    // Remaining R-type functs
    for (int i = 0; i < 5; i++) begin
      set_instr(2'b10, fn_tab[i], 32'h100 + i, 32'h200 + i, 16'h0, 1'b0, 1'b0, 5'd9);
      tick();
      check_val($sformatf("rtype%0d_ctrl", i), {29'd0, ex_ctrl}, {29'd0, ct_tab[i]});
      check_val($sformatf("rtype%0d_data2", i), ex_data2, 32'h200 + i);
      check_val($sformatf("rtype%0d_wr_rt", i), {27'd0, ex_wr_reg}, 32'd3);
    end

    // Load/store: sign-extended immediate
    set_instr(2'b00, 6'd0, 32'h1000, 32'h1234, 16'hFFFC, 1'b1, 1'b0, 5'd0);
    tick();
    check_val("ldst_ctrl", {29'd0, ex_ctrl}, 32'd2);
    check_val("ldst_data2", ex_data2, 32'hFFFFFFFC);
    check_val("ldst_rt_data", ex_rt_data, 32'h1234);

    // Immediate OR: zero-extended immediate
    set_instr(2'b11, 6'd0, 32'h1000, 32'h1234, 16'hFFFC, 1'b1, 1'b0, 5'd0);
    tick();
    check_val("ori_ctrl", {29'd0, ex_ctrl}, 32'd1);
    check_val("ori_data2", ex_data2, 32'h0000FFFC);

    // Branch
    set_instr(2'b01, 6'd0, 32'd20, 32'd5, 16'h8000, 1'b0, 1'b0, 5'd0);
    id_branch = 1'b1; id_reg_write = 1'b0;
    tick();
    check_val("br_ctrl", {29'd0, ex_ctrl}, 32'd6);
    check_val("br_branch", {31'd0, ex_branch}, 32'd1);
    check_val("br_data2", ex_data2, 32'd5);

    // Illegal under stall must not set the sticky flag
    stall = 1'b1;
    set_instr(2'b10, 6'b101010, 32'd1, 32'd2, 16'h0, 1'b0, 1'b1, 5'd8);
    tick();
    check_val("stall_illegal_seen", {31'd0, illegal_seen}, 32'd0);
    check_val("stall_illegal_ctrl", {29'd0, ex_ctrl}, 32'd6);
    stall = 1'b0;

    // Illegal funct
    tick();
    check_val("ill_ctrl", {29'd0, ex_ctrl}, 32'd3);
    check_val("ill_flag", {31'd0, ex_illegal}, 32'd1);
    check_val("ill_reg_write", {31'd0, ex_reg_write}, 32'd0);
    check_val("ill_seen", {31'd0, illegal_seen}, 32'd1);

    // Sticky flag survives three legal instructions
    for (int i = 0; i < 3; i++) begin
      set_instr(2'b10, 6'b100000, 32'd10 + i, 32'd1, 16'h0, 1'b0, 1'b1, 5'd1);
      tick();
      check_val($sformatf("legal%0d_illegal", i), {31'd0, ex_illegal}, 32'd0);
      check_val($sformatf("legal%0d_seen", i), {31'd0, illegal_seen}, 32'd1);
    end
    check_val("legal_reg_write", {31'd0, ex_reg_write}, 32'd1);

    // id_valid=0 captured as bubble
    id_valid = 1'b0;
    tick();
    check_bubble("novalid");

    // Capture a known instruction, then stall 3 cycles with varying inputs
    set_instr(2'b10, 6'b100100, 32'hCAFE0001, 32'h0BADF00D, 16'h0, 1'b0, 1'b1, 5'd17);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(2'b00, 6'd0, 32'h1111 * (i + 1), 32'h2222, 16'h7FF0 + 16'(i), 1'b1, 1'b0, 5'd2);
      tick();
      check_val($sformatf("stall%0d_ctrl", i), {29'd0, ex_ctrl}, 32'd0);
      check_val($sformatf("stall%0d_data1", i), ex_data1, 32'hCAFE0001);
      check_val($sformatf("stall%0d_data2", i), ex_data2, 32'h0BADF00D);
      check_val($sformatf("stall%0d_wr_reg", i), {27'd0, ex_wr_reg}, 32'd17);
    end

    // Stall and flush together -> bubble
    flush = 1'b1;
    tick();
    check_bubble("stallflush");
    flush = 1'b0; stall = 1'b0;

    // Reset asserted mid-stall wins and clears the sticky flag
    set_instr(2'b10, 6'b100101, 32'd3, 32'd4, 16'h0, 1'b0, 1'b1, 5'd6);
    tick();
    check_val("pre_rst_ctrl", {29'd0, ex_ctrl}, 32'd1);
    stall = 1'b1; reset = 1'b1;
    tick();
    check_bubble("rst_stall");
    check_val("rst_stall_seen", {31'd0, illegal_seen}, 32'd0);
    stall = 1'b0; reset = 1'b0;

    // Forwarding: rs=5 with MEM and WB both matching
    set_instr(2'b10, 6'b100000, 32'h11, 32'h22, 16'h0, 1'b0, 1'b1, 5'd7);
    id_rs = 5'd5;
    mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    mem_wr_reg = 5'd5; wb_wr_reg = 5'd5;
    mem_result = 32'hAA; wb_result = 32'hBB;
    tick();
`ifdef EX_ISSUE_FWD_EN
    check_val("fwd_mem_data1", ex_data1, 32'hAA);
`else
    check_val("nofwd_data1", ex_data1, 32'h11);
`endif
    check_val("fwd_rt_nomatch", ex_data2, 32'h22);

    // Only WB matches
    mem_wr_reg = 5'd9;
    tick();
`ifdef EX_ISSUE_FWD_EN
    check_val("fwd_wb_data1", ex_data1, 32'hBB);
`else
    check_val("nofwd_wb_data1", ex_data1, 32'h11);
`endif

    // rs=0 never forwarded
    mem_wr_reg = 5'd0; wb_wr_reg = 5'd0; id_rs = 5'd0;
    tick();
    check_val("fwd_r0_data1", ex_data1, 32'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
